// File: rtl/dcache_pkg.sv
// Shared definitions for the 2-way data cache: address field widths, line size
// and controller state encoding, reused by the controller and the arrays.
package dcache_pkg;
    localparam int DC_ADDR_W     = 32;
    localparam int DC_SETS       = 32;
    localparam int DC_IDX_W      = $clog2(DC_SETS);
    localparam int DC_OFFS_W     = 4;
    localparam int DC_TAG_W      = DC_ADDR_W - DC_IDX_W - DC_OFFS_W;
    localparam int DC_LINE_BYTES = 1 << DC_OFFS_W;
    localparam int DC_WAYS       = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        WBACK  = 3'd2,
        REFILL = 3'd3,
        UPDATE = 3'd4
    } state_e;
endpackage

// File: rtl/dcache_lru.sv
// One LRU bit per set; the stored bit names the way to evict next.
module dcache_lru
    import dcache_pkg::*;
#(
    parameter int SETS = DC_SETS,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IDX_W-1:0] index,
    input  logic             update,
    input  logic             way,
    output logic             lru_way
);
    logic [SETS-1:0] lru_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lru_q <= '0;
        end else if (update) begin
            lru_q[index] <= ~way;
        end
    end

    assign lru_way = lru_q[index];
endmodule

// File: rtl/dcache_ctrl.sv
// Two-way write-back data-cache controller: lookup, victim writeback, line refill
// and array update, with one LRU bit per set.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W = DC_ADDR_W,
    parameter int SETS   = DC_SETS,
    parameter int OFFS_W = DC_OFFS_W,
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = ADDR_W - IDX_W - OFFS_W
) (
    input  logic              clk,
    input  logic              rstn,
    // CPU side: cpu_req is held until the single-cycle cpu_ready pulse; a request
    // is taken only in IDLE. Memory side: each *_req is held until its *_done pulse.
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic [IDX_W-1:0]  index,
    output logic              way_sel,
    output logic              valid_write,
    output logic              tag_write,
    output logic              line_write,
    output logic              dirty_set,
    input  logic [1:0]        valid,
    input  logic [1:0]        tag_hit,
    input  logic [1:0]        dirty,
    input  logic [TAG_W-1:0]  victim_tag,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_done,
    input  logic              mem_wr_done,
    output state_e            dbg_state
);
    state_e            state_q, state_d;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic              we_q;
    logic              victim_q;
    logic [1:0]        hit_vec;
    logic              hit, hit_way, victim;
    logic              lru_way, lru_upd, lru_acc_way;
    logic              unused_offs;

    assign unused_offs = ^cpu_addr[OFFS_W-1:0];

    // tag_hit from an invalid way is meaningless, so it is masked by valid.
    assign hit_vec = valid & tag_hit;
    assign hit     = |hit_vec;
    assign hit_way = ~hit_vec[0];
    assign victim  = !valid[0] ? 1'b0 : (!valid[1] ? 1'b1 : lru_way);

    assign index     = !rstn ? '0 :
                       (state_q == IDLE) ? cpu_addr[OFFS_W +: IDX_W] : idx_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            tag_q    <= '0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            victim_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cpu_req) begin
                tag_q <= cpu_addr[ADDR_W-1 -: TAG_W];
                idx_q <= cpu_addr[OFFS_W +: IDX_W];
                we_q  <= cpu_we;
            end
            if (state_q == LOOKUP) begin
                victim_q <= victim;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cpu_ready   = 1'b0;
        way_sel     = 1'b0;
        valid_write = 1'b0;
        tag_write   = 1'b0;
        line_write  = 1'b0;
        dirty_set   = 1'b0;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = '0;
        lru_upd     = 1'b0;
        lru_acc_way = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    cpu_ready   = 1'b1;
                    way_sel     = hit_way;
                    dirty_set   = we_q;
                    lru_upd     = 1'b1;
                    lru_acc_way = hit_way;
                    state_d     = IDLE;
                end else if (valid[victim] && dirty[victim]) begin
                    state_d = WBACK;
                end else begin
                    state_d = REFILL;
                end
            end
            WBACK: begin
                // way_sel points the tag array at the victim so it can supply victim_tag.
                way_sel    = victim_q;
                mem_wr_req = 1'b1;
                mem_addr   = {victim_tag, idx_q, {OFFS_W{1'b0}}};
                if (mem_wr_done) state_d = REFILL;
            end
            REFILL: begin
                mem_rd_req = 1'b1;
                mem_addr   = {tag_q, idx_q, {OFFS_W{1'b0}}};
                if (mem_rd_done) state_d = UPDATE;
            end
            UPDATE: begin
                way_sel     = victim_q;
                valid_write = 1'b1;
                tag_write   = 1'b1;
                line_write  = 1'b1;
                dirty_set   = we_q;
                cpu_ready   = 1'b1;
                lru_upd     = 1'b1;
                lru_acc_way = victim_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    dcache_lru #(.SETS(SETS)) u_lru (
        .clk     (clk),
        .rstn    (rstn),
        .index   (index),
        .update  (lru_upd),
        .way     (lru_acc_way),
        .lru_way (lru_way)
    );
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a behavioural valid/tag/dirty array model feeds
// the controller, and each access is checked against hand-computed expectations.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cpu_ready;
    logic [4:0]  index;
    logic        way_sel, valid_write, tag_write, line_write, dirty_set;
    logic [1:0]  valid, tag_hit, dirty;
    logic [22:0] victim_tag;
    logic        mem_rd_req, mem_wr_req;
    logic [31:0] mem_addr;
    logic        mem_rd_done = 1'b0, mem_wr_done = 1'b0;
    state_e      dbg_state;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk(clk), .rstn(rstn), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready), .index(index), .way_sel(way_sel), .valid_write(valid_write),
        .tag_write(tag_write), .line_write(line_write), .dirty_set(dirty_set),
        .valid(valid), .tag_hit(tag_hit), .dirty(dirty), .victim_tag(victim_tag),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_rd_done(mem_rd_done), .mem_wr_done(mem_wr_done), .dbg_state(dbg_state)
    );

    // Behavioural arrays driven by the controller's strobes.
    logic [22:0] cur_tag = '0;
    logic [22:0] tag_arr [32][2];
    logic [1:0]  vld_arr [32];
    logic [1:0]  drt_arr [32];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                vld_arr[i]    <= 2'b00;
                drt_arr[i]    <= 2'b00;
                tag_arr[i][0] <= '0;
                tag_arr[i][1] <= '0;
            end
        end else begin
            if (valid_write) vld_arr[index][way_sel] <= 1'b1;
            if (tag_write)   tag_arr[index][way_sel] <= cur_tag;
            if (line_write)     drt_arr[index][way_sel] <= dirty_set;
            else if (dirty_set) drt_arr[index][way_sel] <= 1'b1;
        end
    end

    assign valid      = vld_arr[index];
    assign dirty      = drt_arr[index];
    assign tag_hit    = {tag_arr[index][1] == cur_tag, tag_arr[index][0] == cur_tag};
    assign victim_tag = tag_arr[index][way_sel];

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobes and memory requests must never coincide, nor the two requests.
    always @(negedge clk) begin
        if (rstn) begin
            if (((valid_write | tag_write | line_write | dirty_set) && (mem_rd_req | mem_wr_req))
                || (mem_rd_req && mem_wr_req))
                overlap++;
        end
    end

    int          lat, rd_cnt, rd_addr_chg, first_wr, first_rd;
    logic        saw_rd, saw_wr, saw_upd, saw_dirty, upd_way, dirty_way;
    logic [31:0] rd_addr, wr_addr;

    task automatic access(input logic [31:0] addr, input logic we, input int rd_delay,
                          input bit scramble);
        int cyc;
        bit done_f;
        saw_rd = 0; saw_wr = 0; saw_upd = 0; saw_dirty = 0; upd_way = 0; dirty_way = 0;
        rd_cnt = 0; rd_addr_chg = 0; first_wr = -1; first_rd = -1; lat = -1;
        rd_addr = '0; wr_addr = '0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cur_tag = addr[31:9];
        cyc = 0; done_f = 0;
        while (!done_f && cyc < 200) begin
            @(negedge clk);
            cyc++;
            mem_rd_done = 1'b0;
            mem_wr_done = 1'b0;
            if (dirty_set)  begin saw_dirty = 1; dirty_way = way_sel; end
            if (line_write) begin saw_upd = 1; upd_way = way_sel; end
            if (mem_wr_req) begin
                if (!saw_wr) begin wr_addr = mem_addr; first_wr = cyc; end
                saw_wr = 1;
                mem_wr_done = 1'b1;
            end
            if (mem_rd_req) begin
                if (!saw_rd) begin rd_addr = mem_addr; first_rd = cyc; end
                else if (mem_addr !== rd_addr) rd_addr_chg++;
                saw_rd = 1;
                if (rd_cnt == rd_delay) mem_rd_done = 1'b1;
                rd_cnt++;
            end
            if (cpu_ready) begin
                done_f = 1;
                lat = cyc;
            end else if (scramble && cyc >= 2) begin
                cpu_addr = $urandom;
            end
        end
        if (!done_f) check("access_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    function automatic logic [7:0] out_flags();
        return {cpu_ready, valid_write, tag_write, line_write, dirty_set,
                mem_rd_req, mem_wr_req, way_sel};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] acc;
        int n;
        cpu_addr = 32'h0000_01F0;
        @(negedge clk);
        check("rst_flags", {24'd0, out_flags()}, 32'd0);
        check("rst_index", {27'd0, index}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_state", {29'd0, dbg_state}, {29'd0, IDLE});
        @(posedge clk); #1;
        rstn = 1'b1;
        cpu_addr = 32'h0000_0100;
        @(negedge clk);
        check("idle_index", {27'd0, index}, 32'd16);
        @(posedge clk); #1;

        // Cold miss, then hit on the same line.
        access(32'h0000_0100, 1'b0, 0, 0);
        check("cold_lat", lat, 32'd4);
        check("cold_rd", {31'd0, saw_rd}, 32'd1);
        check("cold_rd_addr", rd_addr, 32'h100);
        check("cold_no_wr", {31'd0, saw_wr}, 32'd0);
        check("cold_upd", {31'd0, saw_upd}, 32'd1);
        check("cold_way", {31'd0, upd_way}, 32'd0);
        access(32'h0000_0100, 1'b0, 0, 0);
        check("hit_lat", lat, 32'd2);
        check("hit_no_rd", {31'd0, saw_rd}, 32'd0);
        check("hit_no_wr", {31'd0, saw_wr}, 32'd0);

        // Set 5: two clean fills, then a third tag evicts the LRU way 0.
        access(32'h0000_0050, 1'b0, 0, 0);
        check("s5a_way", {31'd0, upd_way}, 32'd0);
        access(32'h0000_0250, 1'b0, 0, 0);
        check("s5b_way", {31'd0, upd_way}, 32'd1);
        access(32'h0000_0450, 1'b0, 0, 0);
        check("s5c_way", {31'd0, upd_way}, 32'd0);
        check("s5c_no_wr", {31'd0, saw_wr}, 32'd0);
        check("s5c_rd_addr", rd_addr, 32'h450);

        // Store hit on way 1, then a conflict that evicts the dirty way 1.
        access(32'h0000_0254, 1'b1, 0, 0);
        check("st_hit_lat", lat, 32'd2);
        check("st_hit_dirty", {31'd0, saw_dirty}, 32'd1);
        check("st_hit_way", {31'd0, dirty_way}, 32'd1);
        check("st_hit_no_rd", {31'd0, saw_rd}, 32'd0);
        access(32'h0000_0450, 1'b0, 0, 0);
        check("c_hit_lat", lat, 32'd2);
        access(32'h0000_0650, 1'b0, 0, 0);
        check("wb_seen", {31'd0, saw_wr}, 32'd1);
        check("wb_addr", wr_addr, 32'h250);
        check("wb_first", first_wr, 32'd3);
        check("wb_rd_first", first_rd, 32'd4);
        check("wb_rd_addr", rd_addr, 32'h650);
        check("wb_upd_way", {31'd0, upd_way}, 32'd1);
        check("wb_lat", lat, 32'd5);

        // Store miss over a clean victim: fill marks the line dirty.
        access(32'h0000_0850, 1'b1, 0, 0);
        check("st_miss_no_wr", {31'd0, saw_wr}, 32'd0);
        check("st_miss_way", {31'd0, upd_way}, 32'd0);
        check("st_miss_dirty", {31'd0, saw_dirty}, 32'd1);
        check("st_miss_dway", {31'd0, dirty_way}, 32'd0);
        check("st_miss_lat", lat, 32'd4);

        // Long refill with cpu_addr scrambled while waiting.
        access(32'h0000_0A00, 1'b0, 50, 1);
        check("slow_lat", lat, 32'd54);
        check("slow_rd_cycles", rd_cnt, 32'd51);
        check("slow_rd_addr", rd_addr, 32'hA00);
        check("slow_addr_stable", rd_addr_chg, 32'd0);
        check("no_overlap", overlap, 32'd0);

        // Reset in the middle of a refill, then a stray mem_rd_done in IDLE.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0C30; cur_tag = 23'd6;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_rd_req && n < 20);
        check("refill_reached", {31'd0, mem_rd_req}, 32'd1);
        repeat (3) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_flags", {24'd0, out_flags()}, 32'd0);
        check("mid_rst_index", {27'd0, index}, 32'd0);
        check("mid_rst_mem_addr", mem_addr, 32'd0);
        check("mid_rst_state", {29'd0, dbg_state}, {29'd0, IDLE});
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        mem_rd_done = 1'b1;
        @(negedge clk);
        mem_rd_done = 1'b0;
        acc = '0;
        repeat (4) begin
            acc = acc | out_flags();
            @(negedge clk);
        end
        check("stray_done_flags", {24'd0, acc}, 32'd0);
        check("stray_done_state", {29'd0, dbg_state}, {29'd0, IDLE});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
